// File: rtl/arb_requester.sv
// ---------------------------------------------------------------------------
// arb_requester
//
// Bus master front end for a round-robin arbiter. Burst commands (length-1)
// are queued in a small FIFO. For each queued command the block requests the
// bus, streams the burst beats from the source once granted, and then
// releases the bus for at least one cycle so the arbiter can rotate. Every
// command gets its own request/release cycle, so bursts are never
// concatenated.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake, cmd_len = beats - 1 (0..15)
//   src_valid/src_ready    beat source handshake, src_data = payload
//   req / gnt              request to arbiter / registered grant back
//   bus_valid/bus_last     registered beat strobe / final beat of burst
//   bus_data               registered beat payload
//   err_timeout            sticky: waited TIMEOUT cycles for a grant
//   err_gnt_lost           sticky: grant withdrawn in the middle of a burst
// ---------------------------------------------------------------------------
module arb_requester #(
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic              bus_last,
    output logic [DATA_W-1:0] bus_data,
    output logic              err_timeout,
    output logic              err_gnt_lost
);

    localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cmd_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_last_q, bus_last_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_gnt_lost_q, err_gnt_lost_d;
    logic                push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged on the registered count alone, so a pop in the same
    // cycle never opens the door early.
    assign cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
    assign push      = cmd_valid & cmd_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement can infer a latch.
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        bus_valid_d    = 1'b0;
        bus_last_d     = 1'b0;
        bus_data_d     = bus_data_q;
        err_timeout_d  = err_timeout_q;
        err_gnt_lost_d = err_gnt_lost_q;
        pop            = 1'b0;
        req            = 1'b0;
        src_ready      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                // Only raise a new request once the previous grant is gone.
                if (count_q != '0 && !gnt) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req = 1'b1;
                if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
                if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                end
                if (gnt) begin
                    beat_cnt_d = cmd_mem_q[rd_ptr_q];
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                req = 1'b1;
                if (!gnt) begin
                    // Grant withdrawn mid-burst: abandon the command.
                    err_gnt_lost_d = 1'b1;
                    pop            = 1'b1;
                    state_d        = S_REL;
                end else begin
                    src_ready = src_valid;
                    if (src_valid) begin
                        bus_valid_d = 1'b1;
                        bus_data_d  = src_data;
                        if (beat_cnt_q == 4'd0) begin
                            bus_last_d = 1'b1;
                            pop        = 1'b1;
                            state_d    = S_REL;
                        end else begin
                            beat_cnt_d = beat_cnt_q - 4'd1;
                        end
                    end
                end
            end
            S_REL: begin
                if (!gnt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            beat_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            bus_valid_q    <= 1'b0;
            bus_last_q     <= 1'b0;
            bus_data_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_gnt_lost_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            beat_cnt_q     <= beat_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            bus_valid_q    <= bus_valid_d;
            bus_last_q     <= bus_last_d;
            bus_data_q     <= bus_data_d;
            err_timeout_q  <= err_timeout_d;
            err_gnt_lost_q <= err_gnt_lost_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // NOTE: the command storage has no reset; an entry is only read after
    // it has been written, and the pointers/count carry the reset state.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q] <= cmd_len;
        end
    end

    assign bus_valid    = bus_valid_q;
    assign bus_last     = bus_last_q;
    assign bus_data     = bus_data_q;
    assign err_timeout  = err_timeout_q;
    assign err_gnt_lost = err_gnt_lost_q;

endmodule

// File: tb/tb_arb_requester.sv
// ---------------------------------------------------------------------------
// tb_arb_requester
//
// Scenario tasks drive commands, grant and source beats. Each expected bus
// beat (payload + last flag) is queued when its burst is set up; a negedge
// monitor pops and compares every beat the DUT puts on the bus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arb_requester;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [3:0]        cmd_len = '0;
    logic              src_valid = 1'b0;
    logic [DATA_W-1:0] src_data = '0;
    logic              gnt = 1'b0;
    logic              cmd_ready, src_ready, req;
    logic              bus_valid, bus_last, err_timeout, err_gnt_lost;
    logic [DATA_W-1:0] bus_data;

    arb_requester #(.DATA_W(DATA_W), .CMD_DEPTH(4), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .req         (req),
        .gnt         (gnt),
        .bus_valid   (bus_valid),
        .bus_last    (bus_last),
        .bus_data    (bus_data),
        .err_timeout (err_timeout),
        .err_gnt_lost(err_gnt_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] src_q[$];
    int                compared   = 0;
    int                mismatched = 0;
    int                beats_seen = 0;
    int                lasts_seen = 0;
    logic              gnt_prev   = 1'b0;
    logic [DATA_W-1:0] data_seq   = 8'h11;

    // Observations captured at the negedge of the last cyc() call.
    logic o_req, o_sr, o_cmd_ready, o_err_to, o_err_gl;

    // Bus monitor / scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (bus_valid === 1'b1) begin
            beats_seen++;
            if (bus_last === 1'b1) lasts_seen++;
            compared++;
            if (gnt_prev !== 1'b1) begin
                mismatched++;
                $display("FAIL bus_valid_gnt: gnt on accept cycle=%b, required 1", gnt_prev);
            end
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: data=%h last=%b, required no beat", bus_data, bus_last);
            end else begin
                e = exp_q.pop_front();
                if ({bus_data, bus_last} !== {e.data, e.last}) begin
                    mismatched++;
                    $display("FAIL beat: data=%h last=%b, required data=%h last=%b",
                             bus_data, bus_last, e.data, e.last);
                end
            end
        end
        gnt_prev = gnt;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs, sample at negedge, end 1ns after posedge.
    task automatic cyc(input logic v, input logic g);
        src_valid = v;
        gnt       = g;
        src_data  = (v && src_q.size() > 0) ? src_q[0] : DATA_W'($urandom);
        @(negedge clk);
        o_req       = req;
        o_sr        = src_ready;
        o_cmd_ready = cmd_ready;
        o_err_to    = err_timeout;
        o_err_gl    = err_gnt_lost;
        if (src_valid && src_ready && src_q.size() > 0) void'(src_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] len, output logic accepted);
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(negedge clk);
        accepted = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Queue n_src source beats; the first n_exp are expected on the bus.
    task automatic load_burst(input int n_src, input int n_exp, input bit with_last);
        beat_t b;
        src_q.delete();
        for (int i = 0; i < n_src; i++) begin
            data_seq = data_seq + 8'h35;
            src_q.push_back(data_seq);
            if (i < n_exp) begin
                b.data = data_seq;
                b.last = with_last && (i == n_src - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0);
            if (o_req === 1'b1) begin
                ok = 1;
                break;
            end
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s_req_rise: req=0 after 8 cycles, required 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gnt = 1'b1; src_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++; if (req !== 1'b0) begin mismatched++; $display("FAIL rst_req: %b, required 0", req); end
        compared++; if (src_ready !== 1'b0) begin mismatched++; $display("FAIL rst_src_ready: %b, required 0", src_ready); end
        compared++; if (bus_valid !== 1'b0 || bus_last !== 1'b0) begin mismatched++; $display("FAIL rst_bus_flags: valid=%b last=%b, required 0 0", bus_valid, bus_last); end
        compared++; if (bus_data !== '0) begin mismatched++; $display("FAIL rst_bus_data: %h, required 00", bus_data); end
        compared++; if (err_timeout !== 1'b0 || err_gnt_lost !== 1'b0) begin mismatched++; $display("FAIL rst_err: to=%b gl=%b, required 0 0", err_timeout, err_gnt_lost); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_cmd_ready: %b, required 1", cmd_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0; gnt = 1'b0; src_valid = 1'b0;
        cyc(1'b0, 1'b0);
        compared++; if (o_req !== 1'b0) begin mismatched++; $display("FAIL idle_empty_req: %b, required 0", o_req); end
    endtask

    task automatic test_basic();
        logic acc;
        int b0 = beats_seen, l0 = lasts_seen, nacc = 0, req_drop = 0;
        load_burst(4, 4, 1);
        push_cmd(4'd3, acc);
        wait_req("basic");
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            cyc(1'b1, 1'b1);
            if (o_req !== 1'b1) req_drop++;
            if (o_sr === 1'b1) nacc++;
        end
        compared++; if (nacc != 4) begin mismatched++; $display("FAIL basic_accepts: %0d, required 4", nacc); end
        compared++; if (req_drop != 0) begin mismatched++; $display("FAIL basic_req_held: %0d low cycles, required 0", req_drop); end
        cyc(1'b1, 1'b1);
        compared++; if (o_req !== 1'b0) begin mismatched++; $display("FAIL basic_rel_req: %b, required 0", o_req); end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        compared++; if (o_req !== 1'b0) begin mismatched++; $display("FAIL basic_idle_req: %b, required 0", o_req); end
        compared++; if (beats_seen - b0 != 4 || lasts_seen - l0 != 1) begin mismatched++; $display("FAIL basic_counts: beats=%0d lasts=%0d, required 4 1", beats_seen - b0, lasts_seen - l0); end
        compared++; if (o_err_to !== 1'b0) begin mismatched++; $display("FAIL basic_no_timeout: %b, required 0", o_err_to); end
    endtask

    task automatic test_fifo_full();
        logic acc;
        int n_acc = 0, rises = 0, nbeat = 0, b0 = beats_seen, l0 = lasts_seen;
        logic g = 1'b0, prev_r = 1'b0;
        beat_t b;
        src_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_cmd(4'd0, acc);
            if (acc === 1'b1) n_acc++;
            data_seq = data_seq + 8'h35;
            src_q.push_back(data_seq);
            b.data = data_seq;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
        compared++; if (n_acc != 4) begin mismatched++; $display("FAIL full_pushes: %0d accepted, required 4", n_acc); end
        cyc(1'b0, 1'b0);
        compared++; if (o_cmd_ready !== 1'b0) begin mismatched++; $display("FAIL full_cmd_ready: %b, required 0", o_cmd_ready); end
        push_cmd(4'd0, acc);
        compared++; if (acc !== 1'b0) begin mismatched++; $display("FAIL full_5th_push: accepted=%b, required 0", acc); end
        // Registered arbiter model: grant follows req one cycle later.
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, g);
            if (o_req === 1'b1 && prev_r !== 1'b1) rises++;
            if (o_sr === 1'b1) nbeat++;
            prev_r = o_req;
            g = o_req;
        end
        gnt = 1'b0; src_valid = 1'b0;
        compared++; if (rises != 4) begin mismatched++; $display("FAIL full_req_bursts: %0d req pulses, required 4", rises); end
        compared++; if (nbeat != 4 || beats_seen - b0 != 4 || lasts_seen - l0 != 4) begin mismatched++; $display("FAIL full_beats: acc=%0d bus=%0d lasts=%0d, required 4 4 4", nbeat, beats_seen - b0, lasts_seen - l0); end
        compared++; if (o_req !== 1'b0 || o_cmd_ready !== 1'b1) begin mismatched++; $display("FAIL full_drained: req=%b cmd_ready=%b, required 0 1", o_req, o_cmd_ready); end
    endtask

    task automatic test_timeout();
        logic acc;
        int nacc = 0, b0 = beats_seen, l0 = lasts_seen;
        load_burst(2, 2, 1);
        push_cmd(4'd1, acc);
        wait_req("timeout");
        for (int j = 1; j <= 255; j++) begin
            cyc(1'b0, 1'b0);
            if (j == 254) begin
                compared++; if (o_err_to !== 1'b0) begin mismatched++; $display("FAIL timeout_early: err=%b at cycle 254, required 0", o_err_to); end
            end
            if (j == 255) begin
                compared++; if (o_err_to !== 1'b1 || o_req !== 1'b1) begin mismatched++; $display("FAIL timeout_flag: err=%b req=%b at cycle 255, required 1 1", o_err_to, o_req); end
            end
        end
        for (int i = 0; i < 10 && nacc < 2; i++) begin
            cyc(1'b1, 1'b1);
            if (o_sr === 1'b1) nacc++;
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        compared++; if (beats_seen - b0 != 2 || lasts_seen - l0 != 1) begin mismatched++; $display("FAIL timeout_burst: beats=%0d lasts=%0d, required 2 1", beats_seen - b0, lasts_seen - l0); end
        compared++; if (o_err_to !== 1'b1 || o_req !== 1'b0) begin mismatched++; $display("FAIL timeout_sticky: err=%b req=%b, required 1 0", o_err_to, o_req); end
    endtask

    task automatic test_gnt_lost();
        logic acc, g;
        int nacc = 0, b0 = beats_seen, l0 = lasts_seen, req_bad = 0;
        bit dropped = 0;
        load_burst(8, 3, 0);
        push_cmd(4'd7, acc);
        wait_req("gnt_lost");
        for (int i = 0; i < 20; i++) begin
            g = (nacc < 3);
            cyc(1'b1, g);
            if (!g) begin
                dropped = 1;
                compared++; if (o_sr !== 1'b0 || o_err_gl !== 1'b0) begin mismatched++; $display("FAIL gl_drop_cycle: src_ready=%b err=%b, required 0 0", o_sr, o_err_gl); end
                break;
            end
            if (o_sr === 1'b1) nacc++;
        end
        compared++; if (!dropped) begin mismatched++; $display("FAIL gl_accepts: %0d beats before budget, required 3", nacc); end
        cyc(1'b0, 1'b0);
        compared++; if (o_err_gl !== 1'b1) begin mismatched++; $display("FAIL gl_flag: %b, required 1", o_err_gl); end
        if (o_req !== 1'b0) req_bad++;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            if (o_req !== 1'b0) req_bad++;
        end
        compared++; if (req_bad != 0) begin mismatched++; $display("FAIL gl_cmd_popped: req high %0d cycles, required 0", req_bad); end
        compared++; if (beats_seen - b0 != 3 || lasts_seen - l0 != 0) begin mismatched++; $display("FAIL gl_beats: beats=%0d lasts=%0d, required 3 0", beats_seen - b0, lasts_seen - l0); end
    endtask

    task automatic test_stall();
        logic acc;
        logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int b0 = beats_seen, l0 = lasts_seen;
        load_burst(4, 4, 1);
        push_cmd(4'd3, acc);
        wait_req("stall");
        cyc(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(pat[k], 1'b1);
            compared++;
            if (o_sr !== pat[k] || o_req !== 1'b1) begin
                mismatched++;
                $display("FAIL stall_step%0d: src_ready=%b req=%b, required %b 1", k, o_sr, o_req, pat[k]);
            end
        end
        cyc(1'b0, 1'b1);
        compared++; if (o_req !== 1'b0) begin mismatched++; $display("FAIL stall_rel_req: %b, required 0", o_req); end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        compared++; if (beats_seen - b0 != 4 || lasts_seen - l0 != 1) begin mismatched++; $display("FAIL stall_beats: beats=%0d lasts=%0d, required 4 1", beats_seen - b0, lasts_seen - l0); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        int b0 = beats_seen, req_bad = 0;
        load_burst(6, 1, 0);
        push_cmd(4'd5, acc);
        push_cmd(4'd1, acc);
        push_cmd(4'd2, acc);
        wait_req("rst_mid");
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        compared++; if (o_sr !== 1'b1) begin mismatched++; $display("FAIL rst_mid_beat1: src_ready=%b, required 1", o_sr); end
        rst = 1'b1; src_valid = 1'b1; gnt = 1'b1;
        src_data = src_q.size() > 0 ? src_q[0] : '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({req, src_ready, bus_valid, bus_last, bus_data, err_timeout, err_gnt_lost, cmd_ready}
            !== {4'b0000, {DATA_W{1'b0}}, 3'b001}) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: req=%b sr=%b bv=%b bl=%b bd=%h to=%b gl=%b cr=%b, required 0 0 0 0 00 0 0 1",
                     req, src_ready, bus_valid, bus_last, bus_data, err_timeout, err_gnt_lost, cmd_ready);
        end
        @(posedge clk);
        #1;
        src_q.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            if (o_req !== 1'b0) req_bad++;
        end
        compared++; if (req_bad != 0) begin mismatched++; $display("FAIL rst_mid_queue_flushed: req high %0d cycles, required 0", req_bad); end
        compared++; if (beats_seen - b0 != 1 || exp_q.size() != 0) begin mismatched++; $display("FAIL rst_mid_beats: beats=%0d pending=%0d, required 1 0", beats_seen - b0, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_full();
        test_timeout();
        test_gnt_lost();
        test_stall();
        test_reset_mid();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d beats pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 8, beat data width.
REQ-002 Parameter CMD_DEPTH, default 4, command FIFO entries.
REQ-003 Parameter TIMEOUT, default 255, cycles in REQ before timeout flag.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command FIFO not full.
REQ-008 cmd_len  input  4  burst length minus one (1-16 beats).
REQ-009 src_valid  input  1  beat data available.
REQ-010 src_ready  output  1  beat consumed this cycle.
REQ-011 src_data  input  DATA_W  beat payload.
REQ-012 req  output  1  request to the round-robin arbiter.
REQ-013 gnt  input  1  registered grant from the arbiter.
REQ-014 bus_valid / bus_last  output  1 each  registered beat strobe / final beat of burst.
REQ-015 bus_data  output  DATA_W  registered beat payload.
REQ-016 err_timeout / err_gnt_lost  output  1 each  sticky error flags.

Function
REQ-017 Command FIFO SHALL accept on cmd_valid&cmd_ready; cmd_ready=0 when count==CMD_DEPTH, even if a pop occurs that cycle.
REQ-018 FSM states SHALL be IDLE, REQ, XFER, REL; req=1 exactly in REQ and XFER.
REQ-019 IDLE->REQ when FIFO non-empty and gnt==0; otherwise stay IDLE.
REQ-020 REQ->XFER on gnt==1; beat counter loaded with head cmd_len.
REQ-021 REQ: wait counter increments per cycle, saturates; reaching TIMEOUT SHALL set err_timeout; FSM keeps requesting.
REQ-022 XFER: src_ready = gnt & src_valid; each accepted beat registers src_data onto bus_data with bus_valid=1 the next cycle (latency 1).
REQ-023 Beats with src_valid=0 SHALL stall without losing grant (req held).
REQ-024 Final beat (counter==0) SHALL assert bus_last with bus_valid, pop FIFO head, go to REL.
REQ-025 gnt==0 while in XFER SHALL set err_gnt_lost, pop the command, drop req, go to REL; no beat accepted that cycle.
REQ-026 REL: req=0 for at least one cycle; REL->IDLE only when gnt==0, guaranteeing bus release and arbiter rotation.
REQ-027 Back-to-back commands SHALL each pass through REL; no burst concatenation.
REQ-028 bus_valid SHALL never be 1 unless gnt was 1 on the acceptance cycle.

Reset
REQ-029 rst SHALL force IDLE, empty FIFO, counters 0, req=0, src_ready=0, bus_valid=0, bus_last=0, bus_data=0, err flags=0, cmd_ready=1.
REQ-030 rst mid-XFER SHALL discard the burst and all queued commands; req=0 the cycle after the reset edge.

Verification
REQ-031 Push len=3, gnt rises 2 cycles after req, src_valid=1 -> 4 beats on bus, bus_last on 4th, req low next cycle, REL until gnt=0.
REQ-032 Push 4 commands len=0 -> cmd_ready=0 after 4th; 5th push rejected; 4 single-beat bursts each separated by req=0 cycle.
REQ-033 gnt held 0 for 256 cycles after req -> err_timeout=1 at cycle 255, req still 1; later gnt=1 completes burst.
REQ-034 len=7, gnt deasserted after beat 3 -> err_gnt_lost=1, exactly 3 bus beats, no bus_last, FIFO count decremented.
REQ-035 len=3, src_valid toggled 1,0,0,1,1,1 -> 4 beats total, req continuous throughout, data order preserved.
REQ-036 rst asserted during beat 2 of len=5 with 2 queued -> all outputs at reset values next cycle, cmd_ready=1.
